// File: rtl/mcl_host_credit_gate.sv
// Credit gate between the host bridge transmit path and the manycore link: a two-entry
// request buffer, response credit accounting against the receive FIFO, and a host fence.
module mcl_host_credit_gate #(
    parameter int mcl_width_p       = 32,
    parameter int max_out_credits_p = 16,
    parameter int resp_bit_p        = 0,
    parameter int cw_lp             = $clog2(max_out_credits_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   host_v_i,
    input  logic [mcl_width_p-1:0] host_data_i,
    output logic                   host_ready_o,
    output logic                   link_v_o,
    output logic [mcl_width_p-1:0] link_data_o,
    input  logic                   link_ready_i,
    input  logic                   resp_v_i,
    input  logic                   resp_ready_i,
    input  logic [cw_lp-1:0]       rcv_vacancy_i,
    input  logic                   fence_i,
    output logic                   fence_done_o,
    output logic [cw_lp-1:0]       in_flight_o,
    output logic                   err_o
);

    localparam logic [cw_lp-1:0] max_credits_lp = cw_lp'(max_out_credits_p);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FENCE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                 state;
    state_e                 state_next;

    logic [mcl_width_p-1:0] mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic [cw_lp-1:0]       in_flight;
    logic                   err;

    logic                   rsp_req;
    logic                   credit_ok;
    logic                   buf_full;
    logic                   buf_empty;
    logic                   enq;
    logic                   deq;
    logic                   inc;
    logic                   dec;

    assign rsp_req   = host_data_i[resp_bit_p];
    assign credit_ok = (in_flight < rcv_vacancy_i) && (in_flight < max_credits_lp);
    assign buf_full  = (count == 2'd2);
    assign buf_empty = (count == 2'd0);
    assign enq       = host_v_i & host_ready_o;
    assign deq       = link_v_o & link_ready_i;
    assign inc       = enq & rsp_req;
    assign dec       = resp_v_i & resp_ready_i;

    assign link_v_o    = ~reset_i & ~buf_empty;
    assign link_data_o = mem[rd_ptr];
    assign in_flight_o = in_flight;
    assign err_o       = err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (fence_i) state_next = FENCE;
            FENCE:   if (buf_empty && (in_flight == '0)) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A fence blocks issue in the very cycle it is raised, not one cycle later.
    always_comb begin
        host_ready_o = 1'b0;
        fence_done_o = 1'b0;
        unique case (state)
            RUN:     host_ready_o = ~reset_i & ~fence_i & ~buf_full & (~rsp_req | credit_ok);
            DONE:    fence_done_o = 1'b1;
            default: begin
                host_ready_o = 1'b0;
                fence_done_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= host_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The counter saturates instead of wrapping; an out-of-range move flags err sticky.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            in_flight <= '0;
            err       <= 1'b0;
        end else begin
            if (dec && (in_flight == '0)) begin
                err <= 1'b1;
            end
            if (inc && !dec && (in_flight == max_credits_lp)) begin
                err <= 1'b1;
            end
            if (inc && !dec && (in_flight != max_credits_lp)) begin
                in_flight <= in_flight + cw_lp'(1);
            end else if (dec && !inc && (in_flight != '0)) begin
                in_flight <= in_flight - cw_lp'(1);
            end
        end
    end

endmodule
